goto_sequencer: RTL

Multi-cycle control sequencer for the GOTO (16-bit jump) instruction: fetches the two operand bytes following the opcode from memory, places each on the data bus while pulsing `ld_j1` then `ld_j2` into the J1/J2 jump registers, then transfers the assembled J1:J2 address into the program counter. Sits directly upstream of the J1/J2 registers in the register unit, driving their load strobes and data-bus source, and downstream of the instruction decoder. When the branch condition is false, it skips the operands and advances the PC.

---
 rtl/relay_pkg.sv | 37 +++
 rtl/goto_sequencer_if.sv | 62 ++++++
 rtl/goto_addr_inc.sv | 26 ++
 rtl/goto_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// ============================================================================
//  relay_pkg
//  Shared types and constants for the GOTO jump sequencer.
//  Optional feature macro: GOTO_LINK_EN (adds the LINK state encoding).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package relay_pkg;

  // Default bus widths; the address is assembled from two data bytes.
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Operand byte offsets relative to the first operand address.
  localparam int unsigned OPND_HI_OFS = 0;
  localparam int unsigned OPND_LO_OFS = 1;
  localparam int unsigned OPND_LEN    = 2;

  // Sequencer states, explicitly encoded so the LINK slot stays reserved
  // whether or not the link feature is built.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_HI = 3'd1,
    LOAD_J1  = 3'd2,
    FETCH_LO = 3'd3,
    LOAD_J2  = 3'd4,
`ifdef GOTO_LINK_EN
    LINK     = 3'd5,
`endif
    XFER     = 3'd6,
    SKIP     = 3'd7
  } goto_state_t;

endpackage

`default_nettype wire

// File: rtl/goto_sequencer_if.sv
// ============================================================================
//  goto_sequencer_if
//  Decoder, memory and J-register signals of the GOTO sequencer.
//  master: the sequencer side.  slave: decoder / memory / register unit.
//  Optional feature macro: GOTO_LINK_EN (adds link, ld_xy, xy_data).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface goto_sequencer_if #(
  parameter int ADDR_W = relay_pkg::ADDR_W,
  parameter int DATA_W = relay_pkg::DATA_W
);

  // Decoder side
  logic              start;
  logic              cond_ok;
  logic [ADDR_W-1:0] pc;
  // Memory read port
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  // Register unit
  logic [DATA_W-1:0] data_out;
  logic              ld_j1;
  logic              ld_j2;
  logic [ADDR_W-1:0] j_addr;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;
  // Status
  logic              busy;
  logic              done;
`ifdef GOTO_LINK_EN
  logic              link;
  logic              ld_xy;
  logic [ADDR_W-1:0] xy_data;
`endif

  modport master (
    input  start, cond_ok, pc, mem_ack, mem_data, j_addr,
    output mem_req, mem_addr, data_out, ld_j1, ld_j2, pc_load, pc_next,
    output busy, done
`ifdef GOTO_LINK_EN
    , input link
    , output ld_xy, xy_data
`endif
  );

  modport slave (
    output start, cond_ok, pc, mem_ack, mem_data, j_addr,
    input  mem_req, mem_addr, data_out, ld_j1, ld_j2, pc_load, pc_next,
    input  busy, done
`ifdef GOTO_LINK_EN
    , output link
    , input ld_xy, xy_data
`endif
  );

endinterface

`default_nettype wire

// File: rtl/goto_addr_inc.sv
// ============================================================================
//  goto_addr_inc
//  Combinational operand-address adder: base+1 and base+2, wrapping
//  modulo 2^ADDR_W.  Shared by the second fetch, the skip target and the
//  link return address.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module goto_addr_inc #(
  parameter int ADDR_W = relay_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] plus1,
  output logic [ADDR_W-1:0] plus2
);

  import relay_pkg::*;

  // Truncation to ADDR_W bits gives the required wrap-around.
  assign plus1 = base + ADDR_W'(OPND_LO_OFS);
  assign plus2 = base + ADDR_W'(OPND_LEN);

endmodule

`default_nettype wire

// File: rtl/goto_sequencer.sv
// ============================================================================
//  goto_sequencer
//  Multi-cycle GOTO sequencer: fetches the two operand bytes, strobes them
//  into J1/J2, then loads J1:J2 into the PC.  A false condition skips the
//  operands and advances the PC by two.
//  Optional feature macro: GOTO_LINK_EN (saves pc+2 into XY before jumping).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module goto_sequencer #(
  parameter int ADDR_W = relay_pkg::ADDR_W,
  parameter int DATA_W = relay_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  goto_sequencer_if.master bus
);

  import relay_pkg::*;

  goto_state_t       state;
  logic [ADDR_W-1:0] pc_lat;
  logic [DATA_W-1:0] byte_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] pc_next_r;
  logic              mem_req_r;
  logic              ld_j1_r;
  logic              ld_j2_r;
  logic              pc_load_r;
  logic              done_r;
  logic              busy_r;
  logic              xfer_sel;
`ifdef GOTO_LINK_EN
  logic              link_lat;
  logic              ld_xy_r;
  logic [ADDR_W-1:0] xy_data_r;
`endif

  logic [ADDR_W-1:0] inc_base;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_plus2;

  // Outputs are registered on entry to each state, so in IDLE the adder
  // must see the incoming pc (pc_lat is only written on that same edge).
  assign inc_base = (state == IDLE) ? bus.pc : pc_lat;

  goto_addr_inc #(
    .ADDR_W (ADDR_W)
  ) u_addr_inc (
    .base  (inc_base),
    .plus1 (pc_plus1),
    .plus2 (pc_plus2)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc_lat     <= '0;
      byte_r     <= '0;
      mem_addr_r <= '0;
      pc_next_r  <= '0;
      mem_req_r  <= 1'b0;
      ld_j1_r    <= 1'b0;
      ld_j2_r    <= 1'b0;
      pc_load_r  <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      xfer_sel   <= 1'b0;
`ifdef GOTO_LINK_EN
      link_lat   <= 1'b0;
      ld_xy_r    <= 1'b0;
      xy_data_r  <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      mem_req_r <= 1'b0;
      ld_j1_r   <= 1'b0;
      ld_j2_r   <= 1'b0;
      pc_load_r <= 1'b0;
      done_r    <= 1'b0;
`ifdef GOTO_LINK_EN
      ld_xy_r   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            pc_lat <= bus.pc;
            busy_r <= 1'b1;
`ifdef GOTO_LINK_EN
            // A not-taken branch never links.
            link_lat <= bus.link & bus.cond_ok;
`endif
            if (bus.cond_ok) begin
              state      <= FETCH_HI;
              mem_req_r  <= 1'b1;
              mem_addr_r <= bus.pc;
            end else begin
              state     <= SKIP;
              pc_load_r <= 1'b1;
              done_r    <= 1'b1;
              pc_next_r <= pc_plus2;
            end
          end
        end
        FETCH_HI: begin
          if (bus.mem_ack) begin
            byte_r     <= bus.mem_data;
            mem_addr_r <= '0;
            ld_j1_r    <= 1'b1;
            state      <= LOAD_J1;
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        LOAD_J1: begin
          state      <= FETCH_LO;
          mem_req_r  <= 1'b1;
          mem_addr_r <= pc_plus1;
        end
        FETCH_LO: begin
          if (bus.mem_ack) begin
            byte_r     <= bus.mem_data;
            mem_addr_r <= '0;
            ld_j2_r    <= 1'b1;
            state      <= LOAD_J2;
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        LOAD_J2: begin
`ifdef GOTO_LINK_EN
          if (link_lat) begin
            state     <= LINK;
            ld_xy_r   <= 1'b1;
            xy_data_r <= pc_plus2;
          end else
`endif
          begin
            state     <= XFER;
            pc_load_r <= 1'b1;
            done_r    <= 1'b1;
            xfer_sel  <= 1'b1;
          end
        end
`ifdef GOTO_LINK_EN
        LINK: begin
          state     <= XFER;
          xy_data_r <= '0;
          pc_load_r <= 1'b1;
          done_r    <= 1'b1;
          xfer_sel  <= 1'b1;
        end
`endif
        XFER: begin
          state    <= IDLE;
          busy_r   <= 1'b0;
          xfer_sel <= 1'b0;
        end
        SKIP: begin
          state     <= IDLE;
          busy_r    <= 1'b0;
          pc_next_r <= '0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // J2 is written on the edge that enters XFER, so the jump target is taken
  // straight from the register read-back while in XFER rather than sampled
  // a cycle early.
  assign bus.pc_next  = xfer_sel ? bus.j_addr : pc_next_r;
  // The data bus carries the latched byte only while a J load is strobed.
  assign bus.data_out = (ld_j1_r | ld_j2_r) ? byte_r : '0;

  assign bus.mem_req  = mem_req_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.ld_j1    = ld_j1_r;
  assign bus.ld_j2    = ld_j2_r;
  assign bus.pc_load  = pc_load_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
`ifdef GOTO_LINK_EN
  assign bus.ld_xy    = ld_xy_r;
  assign bus.xy_data  = xy_data_r;
`endif

endmodule

`default_nettype wire
